// File: rtl/ram_init_sequencer.sv
// Per-RAM power-on initialization walker. Writes every entry with its reset value,
// then reports ready and hands the write port over to the owning pipeline stage.
//
// state | meaning
// IDLE  | no walk requested since reset; RAM port held quiet
// INIT  | walking entries 0..DEPTH-1, one write per unstalled cycle
// DONE  | RAM initialized; functional write port passed through
module ram_init_sequencer #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int INIT_MODE   = 0,
  parameter int INIT_OFFSET = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              resetRams_i,
  input  logic              initStall_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  output logic              ramWrEn_o,
  output logic [ADDR_W-1:0] ramWrAddr_o,
  output logic [DATA_W-1:0] ramWrData_o,
  output logic              initBusy_o,
  output logic              ramReady_o,
  output logic              dropWr_o
);

  typedef enum logic [1:0] {IDLE, INIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ram_ready_q, ram_ready_d;
  logic              drop_wr_q, drop_wr_d;
  logic [DATA_W-1:0] init_val;
  logic              init_wr;

  // Mode 2 sum is done at DATA_W width so it wraps modulo 2^DATA_W.
  always_comb begin
    if (INIT_MODE == 1)      init_val = DATA_W'(cnt_q);
    else if (INIT_MODE == 2) init_val = DATA_W'(cnt_q) + DATA_W'(INIT_OFFSET);
    else                     init_val = '0;
  end

  assign init_wr = (state_q == INIT) && !initStall_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_ready_d = ram_ready_q;
    drop_wr_d   = wrEn_i && (state_q != DONE);
    case (state_q)
      IDLE: ;
      INIT: begin
        if (init_wr) begin
          if (cnt_q == LAST) begin
            state_d     = DONE;
            cnt_d       = '0;
            ram_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    // A new init request restarts the walk from any state, overriding the last-entry exit.
    if (resetRams_i) begin
      state_d     = INIT;
      cnt_d       = '0;
      ram_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ram_ready_q <= 1'b0;
      drop_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_ready_q <= ram_ready_d;
      drop_wr_q   <= drop_wr_d;
    end
  end

  always_comb begin
    ramWrEn_o   = 1'b0;
    ramWrAddr_o = '0;
    ramWrData_o = '0;
    if (state_q == DONE) begin
      ramWrEn_o   = wrEn_i;
      ramWrAddr_o = wrAddr_i;
      ramWrData_o = wrData_i;
    end else if (state_q == INIT) begin
      ramWrEn_o   = init_wr;
      ramWrAddr_o = cnt_q;
      ramWrData_o = init_val;
    end
  end

  assign initBusy_o = (state_q == INIT);
  assign ramReady_o = ram_ready_q;
  assign dropWr_o   = drop_wr_q;

endmodule

// File: tb/tb_ram_init_sequencer.sv
// Bench for ram_init_sequencer: three instances (mode 1 / 8b, mode 2 +32 / 6b, mode 2 +32 / 5b)
// share one stimulus stream and are compared each cycle against a walk-position model.
module tb_ram_init_sequencer;
  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       resetRams = 1'b0;
  logic       stall = 1'b0;
  logic       wrEn = 1'b0;
  logic [4:0] wrAddr = '0;
  logic [7:0] wrData = '0;

  logic       en1, en2, en3, busy1, busy2, busy3, rdy1, rdy2, rdy3, drop1, drop2, drop3;
  logic [4:0] a1, a2, a3;
  logic [7:0] d1;
  logic [5:0] d2;
  logic [4:0] d3;

  int checks = 0;
  int errors = 0;
  int mem1 [DEPTH];
  int mem2 [DEPTH];
  int mem3 [DEPTH];

  ram_init_sequencer #(.DEPTH(32), .ADDR_W(5), .DATA_W(8), .INIT_MODE(1), .INIT_OFFSET(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .resetRams_i(resetRams), .initStall_i(stall),
    .wrEn_i(wrEn), .wrAddr_i(wrAddr), .wrData_i(wrData),
    .ramWrEn_o(en1), .ramWrAddr_o(a1), .ramWrData_o(d1),
    .initBusy_o(busy1), .ramReady_o(rdy1), .dropWr_o(drop1));

  ram_init_sequencer #(.DEPTH(32), .ADDR_W(5), .DATA_W(6), .INIT_MODE(2), .INIT_OFFSET(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .resetRams_i(resetRams), .initStall_i(stall),
    .wrEn_i(wrEn), .wrAddr_i(wrAddr), .wrData_i(wrData[5:0]),
    .ramWrEn_o(en2), .ramWrAddr_o(a2), .ramWrData_o(d2),
    .initBusy_o(busy2), .ramReady_o(rdy2), .dropWr_o(drop2));

  ram_init_sequencer #(.DEPTH(32), .ADDR_W(5), .DATA_W(5), .INIT_MODE(2), .INIT_OFFSET(32)) dut3 (
    .clk(clk), .reset_n(reset_n), .resetRams_i(resetRams), .initStall_i(stall),
    .wrEn_i(wrEn), .wrAddr_i(wrAddr), .wrData_i(wrData[4:0]),
    .ramWrEn_o(en3), .ramWrAddr_o(a3), .ramWrData_o(d3),
    .initBusy_o(busy3), .ramReady_o(rdy3), .dropWr_o(drop3));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int init_val(input int inst, input int p);
    if (inst == 1) return p % 256;
    if (inst == 2) return (p + 32) % 64;
    return (p + 32) % 32;
  endfunction

  // Reference model: is a walk active, which entry is next, is the RAM ready, is a drop pending.
  bit m_walk = 0, m_ready = 0, m_drop = 0;
  int m_pos = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_walk = 0; m_ready = 0; m_drop = 0; m_pos = 0;
    end else begin
      m_drop = wrEn && !m_ready;
      if (m_walk && !stall) begin
        if (m_pos == DEPTH - 1) begin
          m_walk = 0; m_ready = 1;
        end else begin
          m_pos++;
        end
      end
      if (resetRams) begin
        m_walk = 1; m_ready = 0; m_pos = 0;
      end
    end
  end

  logic        x_en;
  logic [31:0] x_a, x_d1, x_d2, x_d3;
  bit          x_cmp_ad;
  always @(negedge clk) begin
    if (m_ready) begin
      x_en = wrEn; x_a = 32'(wrAddr);
      x_d1 = 32'(wrData); x_d2 = 32'(wrData[5:0]); x_d3 = 32'(wrData[4:0]);
      x_cmp_ad = 1;
    end else if (m_walk) begin
      x_en = !stall; x_a = 32'(m_pos);
      x_d1 = 32'(init_val(1, m_pos)); x_d2 = 32'(init_val(2, m_pos)); x_d3 = 32'(init_val(3, m_pos));
      x_cmp_ad = !stall;
    end else begin
      x_en = 0; x_a = 0; x_d1 = 0; x_d2 = 0; x_d3 = 0;
      x_cmp_ad = 1;
    end
    chk("wr_en_m1", 32'(en1), 32'(x_en));
    chk("wr_en_m2a", 32'(en2), 32'(x_en));
    chk("wr_en_m2b", 32'(en3), 32'(x_en));
    if (x_cmp_ad) begin
      chk("wr_addr_m1", 32'(a1), x_a);
      chk("wr_addr_m2a", 32'(a2), x_a);
      chk("wr_addr_m2b", 32'(a3), x_a);
      chk("wr_data_m1", 32'(d1), x_d1);
      chk("wr_data_m2a", 32'(d2), x_d2);
      chk("wr_data_m2b", 32'(d3), x_d3);
    end
    chk("busy_m1", 32'(busy1), 32'(m_walk));
    chk("busy_m2a", 32'(busy2), 32'(m_walk));
    chk("busy_m2b", 32'(busy3), 32'(m_walk));
    chk("ready_m1", 32'(rdy1), 32'(m_ready));
    chk("ready_m2a", 32'(rdy2), 32'(m_ready));
    chk("ready_m2b", 32'(rdy3), 32'(m_ready));
    chk("drop_m1", 32'(drop1), 32'(m_drop));
    chk("drop_m2a", 32'(drop2), 32'(m_drop));
    chk("drop_m2b", 32'(drop3), 32'(m_drop));
    if (en1 === 1'b1) mem1[a1] = int'(d1);
    if (en2 === 1'b1) mem2[a2] = int'(d2);
    if (en3 === 1'b1) mem3[a3] = int'(d3);
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rams();
    resetRams = 1'b1;
    cycle();
    resetRams = 1'b0;
  endtask

  // Returns cycles from the request-sampling cycle until ready is seen (-1 on timeout).
  task automatic walk_latency(input int stall_at, input int stall_len, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 200) begin
      stall = (n >= stall_at) && (n < stall_at + stall_len);
      cycle();
      n++;
      if (rdy1 === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) cycle();
    chk("reset_ready", 32'(rdy1), 0);
    chk("reset_busy", 32'(busy1), 0);
    reset_n = 1'b1;
    cycle();

    // Plain walk, then pin the written contents of each instance.
    for (int k = 0; k < DEPTH; k++) begin mem1[k] = -1; mem2[k] = -1; mem3[k] = -1; end
    pulse_rams();
    walk_latency(1000, 0, lat);
    chk("lat_plain", lat, 33);
    for (int k = 0; k < DEPTH; k++) chk("mem_mode1", mem1[k], k);
    chk("mem_mode2_w6_e0", mem2[0], 32);
    chk("mem_mode2_w6_e31", mem2[31], 63);
    chk("mem_mode2_w5_e0", mem3[0], 0);
    chk("mem_mode2_w5_e31", mem3[31], 31);

    // Three stalled cycles at entry 3.
    pulse_rams();
    walk_latency(3, 3, lat);
    chk("lat_stall3", lat, 36);

    // Functional write during the walk is dropped, then passes through once ready.
    pulse_rams();
    repeat (10) cycle();
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 8'h55;
    #2;
    chk("walk_addr_c10", 32'(a1), 10);
    chk("walk_data_c10", 32'(d1), 10);
    cycle();
    wrEn = 1'b0;
    chk("drop_pulse", 32'(drop1), 1);
    walk_latency(1000, 0, lat);
    chk("ready_after_drop", 32'(rdy1), 1);
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 8'h55;
    #1;
    chk("pass_en", 32'(en1), 1);
    chk("pass_addr", 32'(a1), 7);
    chk("pass_data", 32'(d1), 32'h55);
    cycle();
    wrEn = 1'b0;
    chk("no_drop_done", 32'(drop1), 0);

    // Re-request mid-walk restarts from entry 0.
    pulse_rams();
    repeat (20) cycle();
    pulse_rams();
    walk_latency(1000, 0, lat);
    chk("lat_restart", lat, 33);

    // Request held for several cycles keeps rewriting entry 0.
    resetRams = 1'b1;
    repeat (4) cycle();
    resetRams = 1'b0;
    walk_latency(1000, 0, lat);
    chk("lat_held", lat, 33);

    // Asynchronous reset mid-walk.
    pulse_rams();
    repeat (15) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_en", 32'(en1), 0);
    chk("areset_addr", 32'(a1), 0);
    chk("areset_busy", 32'(busy1), 0);
    chk("areset_ready", 32'(rdy1), 0);
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (10) cycle();
    chk("post_reset_ready", 32'(rdy1), 0);
    chk("post_reset_busy", 32'(busy1), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      resetRams = ($urandom_range(0, 49) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      wrEn      = ($urandom_range(0, 2) == 0);
      wrAddr    = 5'($urandom);
      wrData    = 8'($urandom);
      cycle();
    end
    reset_n = 1'b1; resetRams = 1'b0; stall = 1'b0; wrEn = 1'b0;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
